// File: rtl/ce_pkg.sv
// ----------------------------------------------------------------------------
// ce_pkg : shared state encoding and CE width rule for the CE sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // CE partial-sum width for N-bit features and M-bit weights
  function automatic int ce_dw(input int n, input int m);
    return n + m + 15;
  endfunction

  localparam int CE_N  = 2;
  localparam int CE_M  = 2;
  localparam int CE_DW = ce_dw(CE_N, CE_M);

endpackage

`default_nettype wire

// File: rtl/ce_acc.sv
// ----------------------------------------------------------------------------
// ce_acc : per-pixel signed accumulator, result counters, ReLU, output register
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ce_acc #(
  parameter int DW   = 19,
  parameter int AW   = 16,
  parameter int PW   = 4,
  parameter int RELU = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    d_i,
  input  logic [AW-1:0]    cfg_pix_i,
  input  logic [PW-1:0]    cfg_pass_i,
  output logic [DW+PW-1:0] acc_out_o,
  output logic             acc_valid_o,
  output logic             acc_last_o
);

  localparam int ACCW = DW + PW;

  logic [PW-1:0]   res_pass_q, res_pass_d;
  logic [AW-1:0]   res_pix_q,  res_pix_d;
  logic [ACCW-1:0] acc_q,      acc_d;
  logic [ACCW-1:0] out_q,      out_d;
  logic            valid_q,    valid_d;
  logic            last_q,     last_d;
  logic [ACCW-1:0] w_d_ext;
  logic [ACCW-1:0] w_sum;

  assign w_d_ext = {{PW{d_i[DW-1]}}, d_i};
  assign w_sum   = (res_pass_q == '0) ? w_d_ext : (acc_q + w_d_ext);

  always_comb begin
    res_pass_d = res_pass_q;
    res_pix_d  = res_pix_q;
    acc_d      = acc_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    if (clr_i) begin
      res_pass_d = '0;
      res_pix_d  = '0;
    end else if (en_i) begin
      acc_d = w_sum;
      if (res_pass_q == cfg_pass_i - PW'(1)) begin
        res_pass_d = '0;
        res_pix_d  = res_pix_q + AW'(1);
        // Sum width covers 2^PW-1 terms, so only the sign bit matters for ReLU
        out_d      = ((RELU != 0) && w_sum[ACCW-1]) ? '0 : w_sum;
        valid_d    = 1'b1;
        last_d     = (res_pix_q == cfg_pix_i - AW'(1));
      end else begin
        res_pass_d = res_pass_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_pass_q <= '0;
      res_pix_q  <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      res_pass_q <= res_pass_d;
      res_pix_q  <= res_pix_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign acc_out_o   = out_q;
  assign acc_valid_o = valid_q;
  assign acc_last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/ce_sched.sv
// ----------------------------------------------------------------------------
// ce_sched : CE job sequencer - FSM, operand issue counters, result accumulate
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ce_sched
  import ce_pkg::*;
#(
  parameter int DW   = CE_DW,
  parameter int AW   = 16,
  parameter int PW   = 4,
  parameter int RELU = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    cfg_pixels,
  input  logic [PW-1:0]    cfg_passes,
  output logic             busy,
  output logic             done,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [AW-1:0]    pix_idx,
  output logic [PW-1:0]    pass_idx,
  output logic             ce_en_in,
  input  logic [DW-1:0]    ce_d_out,
  input  logic             ce_en_out,
  output logic [DW+PW-1:0] acc_out,
  output logic             acc_valid
);

  state_e        state_q, state_d;
  logic [AW-1:0] cfg_pix_q, pix_q, pix_d;
  logic [PW-1:0] cfg_pass_q, pass_q, pass_d;
  logic          w_start_ok;
  logic          w_issue;
  logic          w_last_pass;
  logic          w_last_pix;
  logic          w_res_en;
  logic          w_acc_last;

  assign w_start_ok  = start && (state_q == ST_IDLE);
  assign w_issue     = src_valid && (state_q == ST_RUN);
  assign w_last_pass = (pass_q == cfg_pass_q - PW'(1));
  assign w_last_pix  = (pix_q == cfg_pix_q - AW'(1));
  // Results arriving outside an active job cannot belong to it
  assign w_res_en    = ce_en_out && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    pass_d    = pass_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    src_ready = (state_q == ST_RUN);
    ce_en_in  = w_issue;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pix_d   = '0;
          pass_d  = '0;
          state_d = ((cfg_pixels != '0) && (cfg_passes != '0)) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_issue) begin
          if (w_last_pass) begin
            pass_d = '0;
            pix_d  = pix_q + AW'(1);
            if (w_last_pix) state_d = ST_DRAIN;
          end else begin
            pass_d = pass_q + PW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (w_acc_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      pass_q     <= '0;
      cfg_pix_q  <= '0;
      cfg_pass_q <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      pass_q  <= pass_d;
      if (w_start_ok) begin
        cfg_pix_q  <= cfg_pixels;
        cfg_pass_q <= cfg_passes;
      end
    end
  end

  assign pix_idx  = pix_q;
  assign pass_idx = pass_q;

  ce_acc #(
    .DW   (DW),
    .AW   (AW),
    .PW   (PW),
    .RELU (RELU)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (w_start_ok),
    .en_i        (w_res_en),
    .d_i         (ce_d_out),
    .cfg_pix_i   (cfg_pix_q),
    .cfg_pass_i  (cfg_pass_q),
    .acc_out_o   (acc_out),
    .acc_valid_o (acc_valid),
    .acc_last_o  (w_acc_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_ce_sched.sv
// ----------------------------------------------------------------------------
// tb_ce_sched : scoreboard bench for ce_sched, ReLU and linear builds side by side
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ce_sched;
  import ce_pkg::*;

  localparam int DW   = 19;
  localparam int AW   = 16;
  localparam int PW   = 4;
  localparam int ACCW = DW + PW;
  localparam int LAT  = 3;

  logic            clk, rst, start, src_valid, ce_en_out;
  logic [AW-1:0]   cfg_pixels;
  logic [PW-1:0]   cfg_passes;
  logic [DW-1:0]   ce_d_out;

  logic            busy_a, done_a, src_ready_a, ce_en_in_a, acc_valid_a;
  logic [AW-1:0]   pix_idx_a;
  logic [PW-1:0]   pass_idx_a;
  logic [ACCW-1:0] acc_out_a;
  logic            busy_b, done_b, src_ready_b, ce_en_in_b, acc_valid_b;
  logic [AW-1:0]   pix_idx_b;
  logic [PW-1:0]   pass_idx_b;
  logic [ACCW-1:0] acc_out_b;

  ce_sched #(.DW(DW), .AW(AW), .PW(PW), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .cfg_pixels(cfg_pixels), .cfg_passes(cfg_passes),
    .busy(busy_a), .done(done_a), .src_valid(src_valid), .src_ready(src_ready_a),
    .pix_idx(pix_idx_a), .pass_idx(pass_idx_a), .ce_en_in(ce_en_in_a),
    .ce_d_out(ce_d_out), .ce_en_out(ce_en_out), .acc_out(acc_out_a), .acc_valid(acc_valid_a)
  );

  ce_sched #(.DW(DW), .AW(AW), .PW(PW), .RELU(0)) u_lin (
    .clk(clk), .rst(rst), .start(start), .cfg_pixels(cfg_pixels), .cfg_passes(cfg_passes),
    .busy(busy_b), .done(done_b), .src_valid(src_valid), .src_ready(src_ready_b),
    .pix_idx(pix_idx_b), .pass_idx(pass_idx_b), .ce_en_in(ce_en_in_b),
    .ce_d_out(ce_d_out), .ce_en_out(ce_en_out), .acc_out(acc_out_b), .acc_valid(acc_valid_b)
  );

  int            n_pass, n_total;
  int            done_cnt, acc_cnt, issue_cnt;
  longint        cyc, last_acc_cyc, done_cyc;
  logic [DW-1:0] ce_vals[$];
  int            exp_pix[$], exp_pass[$];
  longint        exp_sum[$];
  longint        dir_vals[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // CE stand-in: fixed-latency, non-stallable pipe returning the next queued value per issue
  initial begin : ce_model
    bit            pv[LAT];
    logic [DW-1:0] pd[LAT];
    bit            pend_v;
    logic [DW-1:0] pend_d;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    ce_en_out = 1'b0;
    ce_d_out  = '0;
    forever begin
      @(negedge clk);
      pend_v = 1'b0;
      pend_d = '0;
      if (!rst) begin
        for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      end else if (ce_en_in_a) begin
        pend_v = 1'b1;
        if (ce_vals.size() > 0) pend_d = ce_vals.pop_front();
      end
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = pend_v;
      pd[0] = pend_d;
      ce_en_out = pv[LAT-1];
      ce_d_out  = pd[LAT-1];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues or presents a result
  int     mon_pix, mon_pass;
  longint mon_s, mon_a, mon_b;
  always @(negedge clk) begin
    if (rst) begin
      if (ce_en_in_a || ce_en_in_b) begin
        issue_cnt++;
        check(ce_en_in_a == ce_en_in_b, "en_in_builds_agree", longint'(ce_en_in_b), longint'(ce_en_in_a));
        check(src_valid == 1'b1, "en_in_with_src_valid", longint'(src_valid), 1);
        if (exp_pix.size() == 0) begin
          check(1'b0, "unexpected_issue", longint'(pix_idx_a) * 256 + pass_idx_a, -1);
        end else begin
          mon_pix  = exp_pix.pop_front();
          mon_pass = exp_pass.pop_front();
          check((int'(pix_idx_a) == mon_pix) && (int'(pass_idx_a) == mon_pass), "issue_index",
                longint'(pix_idx_a) * 256 + pass_idx_a, longint'(mon_pix) * 256 + mon_pass);
        end
      end
      if (acc_valid_a || acc_valid_b) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        check(acc_valid_a == acc_valid_b, "acc_valid_builds_agree", longint'(acc_valid_b), longint'(acc_valid_a));
        if (exp_sum.size() == 0) begin
          check(1'b0, "unexpected_acc_valid", longint'($signed(acc_out_b)), -1);
        end else begin
          mon_s = exp_sum.pop_front();
          mon_a = $signed(acc_out_a);
          mon_b = $signed(acc_out_b);
          check(mon_b == mon_s, "acc_out_linear", mon_b, mon_s);
          check(mon_a == ((mon_s < 0) ? 0 : mon_s), "acc_out_relu", mon_a, (mon_s < 0) ? 0 : mon_s);
        end
      end
      if (done_a || done_b) begin
        done_cnt++;
        done_cyc = cyc;
        check(done_a == done_b, "done_builds_agree", longint'(done_b), longint'(done_a));
      end
    end
  end

  task automatic prep(input int pix, input int pas, input int vmode);
    longint        v, sum;
    logic [DW-1:0] r;
    if (pix == 0 || pas == 0) return;
    for (int p = 0; p < pix; p++) begin
      sum = 0;
      for (int q = 0; q < pas; q++) begin
        case (vmode)
          0:       v = dir_vals[p * pas + q];
          1:       begin r = DW'($urandom); v = $signed(r); end
          default: v = -(longint'(1) <<< (DW - 1));
        endcase
        ce_vals.push_back(DW'(v));
        exp_pix.push_back(p);
        exp_pass.push_back(q);
        sum += v;
      end
      exp_sum.push_back(sum);
    end
  endtask

  // Accepts a job and checks the cycle right after the start edge
  task automatic launch(input int pix, input int pas, input int vmode);
    int i0;
    prep(pix, pas, vmode);
    i0 = issue_cnt;
    src_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_pixels = AW'(pix);
    cfg_passes = PW'(pas);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_pixels = AW'($urandom);
    cfg_passes = PW'($urandom);
    if (pix != 0 && pas != 0) begin
      check(busy_a && src_ready_a && busy_b && src_ready_b, "run_entry",
            longint'({busy_a, src_ready_a}), 3);
    end else begin
      check(done_a && busy_a && !src_ready_a, "zero_cfg_done",
            longint'({done_a, busy_a, src_ready_a}), 6);
      @(posedge clk); #1;
      check(!busy_a && !done_a && !busy_b, "zero_cfg_idle", longint'({busy_a, done_a}), 0);
      check(issue_cnt == i0, "zero_cfg_no_issue", issue_cnt - i0, 0);
    end
  endtask

  task automatic job(input int pix, input int pas, input int vmode, input int vpat, input bit inject);
    int d0, i0, n;
    d0 = done_cnt;
    i0 = issue_cnt;
    launch(pix, pas, vmode);
    if (pix == 0 || pas == 0) return;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      case (vpat)
        0:       src_valid = 1'b1;
        1:       src_valid = (n % 3 == 0);
        default: src_valid = 1'($urandom_range(0, 1));
      endcase
      start = inject && (n == 3);
      if (start) begin
        cfg_pixels = AW'($urandom_range(1, 9));
        cfg_passes = PW'($urandom_range(1, 9));
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    src_valid = 1'b0;
    if (n >= 3000) begin
      check(1'b0, "job_timeout", n, 3000);
    end else begin
      check(!busy_a && !busy_b, "idle_after_done", longint'({busy_a, busy_b}), 0);
      check(done_cyc == last_acc_cyc + 1, "done_after_last_acc", done_cyc - last_acc_cyc, 1);
    end
    check(issue_cnt - i0 == pix * pas, "issue_count", issue_cnt - i0, pix * pas);
    check(exp_sum.size() == 0 && exp_pix.size() == 0, "scoreboard_drained",
          exp_sum.size() + exp_pix.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check(!busy_a && !done_a && !acc_valid_a && !src_ready_a && !ce_en_in_a, {tag, "_flags"},
          longint'({busy_a, done_a, acc_valid_a, src_ready_a, ce_en_in_a}), 0);
    check(pix_idx_a == '0 && pass_idx_a == '0, {tag, "_indices"},
          longint'(pix_idx_a) * 256 + pass_idx_a, 0);
    check(acc_out_a == '0 && acc_out_b == '0 && !busy_b && !acc_valid_b, {tag, "_acc_out"},
          longint'(acc_out_a) + longint'(acc_out_b), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int d0;
    n_pass = 0; n_total = 0;
    done_cnt = 0; acc_cnt = 0; issue_cnt = 0;
    last_acc_cyc = 0; done_cyc = 0;
    rst = 1'b0; start = 1'b0; src_valid = 1'b0;
    cfg_pixels = '0; cfg_passes = '0;
    repeat (3) @(posedge clk);
    #1;
    src_valid = 1'b1;
    #1;
    check_zero("reset_state");
    src_valid = 1'b0;
    rst = 1'b1;

    dir_vals = '{5, -2, 7};
    job(3, 1, 0, 0, 1'b0);
    dir_vals = '{10, -4, 1, 3, 3, 3};
    job(2, 3, 0, 0, 1'b0);
    job(2, 2, 1, 1, 1'b0);
    job(2, 15, 2, 0, 1'b0);
    launch(0, 3, 1);
    launch(4, 0, 1);
    job(3, 2, 1, 2, 1'b1);
    for (int j = 0; j < 5; j++)
      job(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)), 1, 2, 1'b0);

    launch(4, 2, 1);
    repeat (4) begin src_valid = 1'b1; @(posedge clk); #1; end
    rst = 1'b0;
    ce_vals.delete();
    exp_pix.delete();
    exp_pass.delete();
    exp_sum.delete();
    @(posedge clk); #1;
    check_zero("mid_run_reset");
    d0 = done_cnt;
    rst = 1'b1;
    src_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check(done_cnt == d0, "no_done_after_reset", done_cnt - d0, 0);
    dir_vals = '{4};
    job(1, 1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
